// File: rtl/user_io_csr_master.sv
// CSR initiator for the user-IO black-box port: issues one read/write at a time,
// waits for the read ack or a timeout, then returns the result on a valid/ready response port.
module user_io_csr_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clk_per,
  input  logic              reset_per_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_wr,
  input  logic [15:0]       cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [63:0]       rsp_data,
  output logic              rsp_err,
  output logic [15:0]       o_csr_addr,
  output logic [63:0]       o_csr_data,
  output logic              o_csr_wr_vld,
  output logic              o_csr_rd_vld,
  input  logic [63:0]       i_csr_data,
  input  logic              i_csr_rd_ack,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CNT_W-1:0]  stray_ack_cnt
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_reg;
  logic             wr_reg;
  logic [WCW-1:0]   wait_cnt_reg;

  always_ff @(posedge clk_per or negedge reset_per_n) begin
    if (!reset_per_n) begin
      state_reg     <= S_IDLE;
      wr_reg        <= 1'b0;
      wait_cnt_reg  <= '0;
      cmd_rdy       <= 1'b1;
      rsp_vld       <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      o_csr_addr    <= '0;
      o_csr_data    <= '0;
      o_csr_wr_vld  <= 1'b0;
      o_csr_rd_vld  <= 1'b0;
      timeout_cnt   <= '0;
      stray_ack_cnt <= '0;
    end else begin
      // Strobes are single-cycle: only the acceptance cycle raises them.
      o_csr_wr_vld <= 1'b0;
      o_csr_rd_vld <= 1'b0;

      // An ack is only meaningful while a read is outstanding; anything else is counted and dropped.
      if (i_csr_rd_ack && (state_reg != S_WAIT) && (stray_ack_cnt != CNT_MAX))
        stray_ack_cnt <= stray_ack_cnt + 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (cmd_vld) begin
            wr_reg       <= cmd_wr;
            o_csr_addr   <= cmd_addr;
            o_csr_data   <= cmd_wdata;
            o_csr_wr_vld <= cmd_wr;
            o_csr_rd_vld <= ~cmd_wr;
            cmd_rdy      <= 1'b0;
            state_reg    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (wr_reg) begin
            // Writes are posted: no ack exists, so respond immediately.
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_vld   <= 1'b1;
            state_reg <= S_RESP;
          end else begin
            wait_cnt_reg <= '0;
            state_reg    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_csr_rd_ack) begin
            rsp_data  <= i_csr_data;
            rsp_err   <= 1'b0;
            rsp_vld   <= 1'b1;
            state_reg <= S_RESP;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_vld   <= 1'b1;
            state_reg <= S_RESP;
            if (timeout_cnt != CNT_MAX)
              timeout_cnt <= timeout_cnt + 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_rdy) begin
            rsp_vld   <= 1'b0;
            cmd_rdy   <= 1'b1;
            state_reg <= S_IDLE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          cmd_rdy   <= 1'b1;
          rsp_vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_io_csr_master.sv
// Randomized bench for user_io_csr_master: a behavioural bbox responder with programmable
// ack delay plus a transaction-level reference model of response, latency and counters.
module tb_user_io_csr_master;

  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CNT_SAT = (1 << CW) - 1;
  localparam logic [63:0] UNMAPPED = 64'hdeadbeefdeadbeef;

  logic          clk_per = 1'b0;
  logic          reset_per_n;
  logic          cmd_vld, cmd_rdy, cmd_wr;
  logic [15:0]   cmd_addr;
  logic [63:0]   cmd_wdata;
  logic          rsp_vld, rsp_rdy, rsp_err;
  logic [63:0]   rsp_data;
  logic [15:0]   o_csr_addr;
  logic [63:0]   o_csr_data;
  logic          o_csr_wr_vld, o_csr_rd_vld;
  logic [63:0]   i_csr_data;
  logic          i_csr_rd_ack;
  logic [CW-1:0] timeout_cnt, stray_ack_cnt;

  user_io_csr_master #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk_per(clk_per), .reset_per_n(reset_per_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_csr_addr(o_csr_addr), .o_csr_data(o_csr_data),
    .o_csr_wr_vld(o_csr_wr_vld), .o_csr_rd_vld(o_csr_rd_vld),
    .i_csr_data(i_csr_data), .i_csr_rd_ack(i_csr_rd_ack),
    .timeout_cnt(timeout_cnt), .stray_ack_cnt(stray_ack_cnt)
  );

  always #5 clk_per = ~clk_per;

  int cyc = 0;
  always @(posedge clk_per) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- bbox responder model ----------------
  logic [63:0] bbox_mem [0:63];
  logic [63:0] ref_mem  [0:63];
  int          cd = 0;          // cycles until the pending ack fires; 0 = none pending
  int          cur_delay = 1;   // ack delay after rd_vld; 0 = never ack
  int          wr_pulses = 0, rd_pulses = 0;
  logic        resp_ack = 1'b0, stray_ack = 1'b0;
  logic [63:0] resp_rdata = '0, stray_data = '0;

  assign i_csr_rd_ack = resp_ack | stray_ack;
  assign i_csr_data   = resp_ack ? resp_rdata : stray_data;

  initial begin
    forever begin
      @(posedge clk_per);
      #1;
      if (cd == 1) begin
        resp_ack   = 1'b1;
        resp_rdata = (o_csr_addr < 16'd64) ? bbox_mem[o_csr_addr[5:0]] : UNMAPPED;
      end else begin
        resp_ack = 1'b0;
      end
      if (cd > 0) cd--;
      if (o_csr_wr_vld) begin
        wr_pulses++;
        if (o_csr_addr < 16'd64) bbox_mem[o_csr_addr[5:0]] = o_csr_data;
      end
      if (o_csr_rd_vld) begin
        rd_pulses++;
        cd = cur_delay;
      end
    end
  end

  // ---------------- reference model state ----------------
  int exp_to = 0;
  int exp_stray = 0;

  function automatic logic [63:0] ref_read(input logic [15:0] a);
    return (a < 16'd64) ? ref_mem[a[5:0]] : UNMAPPED;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_rdy"}, cmd_rdy, 1);
    check_eq({tag, "_rsp_vld"}, rsp_vld, 0);
    check_eq({tag, "_rsp_data"}, rsp_data, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_addr"}, o_csr_addr, 0);
    check_eq({tag, "_data"}, o_csr_data, 0);
    check_eq({tag, "_wr_vld"}, o_csr_wr_vld, 0);
    check_eq({tag, "_rd_vld"}, o_csr_rd_vld, 0);
    check_eq({tag, "_timeout_cnt"}, timeout_cnt, 0);
    check_eq({tag, "_stray_cnt"}, stray_ack_cnt, 0);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((cd != 0 || !cmd_rdy) && n < 100) begin
      @(negedge clk_per);
      n++;
    end
    @(negedge clk_per);
    check_eq("quiet_cmd_rdy", cmd_rdy, 1);
    check_eq("timeout_cnt", timeout_cnt, exp_to);
    check_eq("stray_cnt", stray_ack_cnt, exp_stray);
  endtask

  task automatic do_cmd(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                        input int delay, input int stall);
    int n, acc, wr0, rd0, exp_off;
    logic [63:0] exp_data;
    bit exp_err;
    wait_quiet();
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    cur_delay = delay;
    cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk_per);
    cmd_vld = 1'b0;
    acc = cyc;
    if (wr) begin
      if (addr < 16'd64) ref_mem[addr[5:0]] = wd;
      exp_off = 2; exp_data = '0; exp_err = 1'b0;
    end else if (delay >= 1 && delay <= TO) begin
      exp_off = 2 + delay; exp_data = ref_read(addr); exp_err = 1'b0;
    end else begin
      exp_off = 2 + TO; exp_data = '0; exp_err = 1'b1;
      if (exp_to < CNT_SAT) exp_to++;
      if (delay > TO && exp_stray < CNT_SAT) exp_stray++;
    end
    n = 0;
    while (!rsp_vld && n < 40) begin
      @(negedge clk_per);
      n++;
    end
    check_eq("rsp_latency", cyc - acc + 1, exp_off);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("cmd_rdy_busy", cmd_rdy, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_per);
      check_eq("stall_rsp_vld", rsp_vld, 1);
      check_eq("stall_rsp_data", rsp_data, exp_data);
      check_eq("stall_cmd_rdy", cmd_rdy, 0);
    end
    rsp_rdy = 1'b1;
    @(negedge clk_per);
    rsp_rdy = 1'b0;
    check_eq("rsp_vld_drop", rsp_vld, 0);
    check_eq("cmd_rdy_back", cmd_rdy, 1);
    check_eq("wr_pulses", wr_pulses - wr0, wr ? 1 : 0);
    check_eq("rd_pulses", rd_pulses - rd0, wr ? 0 : 1);
    $display("txn %s addr=0x%04h wdata=0x%016h delay=%0d stall=%0d -> rsp_data=0x%016h err=%0b",
             wr ? "WR" : "RD", addr, wd, delay, stall, rsp_data, rsp_err);
  endtask

  task automatic stray_pulse();
    stray_data = {$urandom, $urandom};
    stray_ack = 1'b1;
    @(negedge clk_per);
    stray_ack = 1'b0;
    if (exp_stray < CNT_SAT) exp_stray++;
    @(negedge clk_per);
    check_eq("stray_no_rsp", rsp_vld, 0);
    check_eq("stray_cnt_live", stray_ack_cnt, exp_stray);
    $display("stray ack injected -> stray_ack_cnt=%0d", stray_ack_cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      bbox_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    reset_per_n = 1'b0;
    cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_rdy = 1'b0;
    repeat (3) @(negedge clk_per);
    check_reset_outputs("reset");
    reset_per_n = 1'b1;

    // Directed scenarios
    do_cmd(1'b1, 16'h0008, 64'h1122334455667788, 1, 0);
    do_cmd(1'b0, 16'h0008, '0, 1, 0);
    do_cmd(1'b0, 16'h0040, '0, 1, 0);
    do_cmd(1'b0, 16'h0008, '0, 0, 0);           // never acked: timeout
    do_cmd(1'b1, 16'h0010, 64'hcafef00d12345678, 1, 0);
    do_cmd(1'b0, 16'h0010, '0, TO, 0);          // ack on last wait cycle wins
    do_cmd(1'b0, 16'h0008, '0, 1, 5);           // response held 5 cycles
    wait_quiet();
    stray_pulse();
    check_eq("first_stray", stray_ack_cnt, 1);
    do_cmd(1'b0, 16'h0003, '0, TO + 1, 0);      // late ack after timeout is stray

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit wr;
      logic [15:0] a;
      int r, d;
      wr = bit'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, 63));
      r  = $urandom_range(0, 9);
      if (r <= 5)      d = $urandom_range(1, 3);
      else if (r == 6) d = TO;
      else if (r == 7) d = TO + 1 + $urandom_range(0, 2);
      else if (r == 8) d = 0;
      else             d = $urandom_range(4, TO - 1);
      do_cmd(wr, a, {$urandom, $urandom}, d, $urandom_range(0, 3));
    end

    // Counter saturation
    for (int i = 0; i < CNT_SAT + 2; i++) do_cmd(1'b0, 16'h0001, '0, 0, 0);
    wait_quiet();
    for (int i = 0; i < CNT_SAT + 2; i++) stray_pulse();
    check_eq("timeout_sat", timeout_cnt, CNT_SAT);
    check_eq("stray_sat", stray_ack_cnt, CNT_SAT);

    // Reset in WAIT; the late ack lands after reset and must count as stray
    wait_quiet();
    begin
      int rd0;
      rd0 = rd_pulses;
      cur_delay = 8;
      cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0008; cmd_wdata = '0;
      @(negedge clk_per);
      cmd_vld = 1'b0;
      repeat (2) @(negedge clk_per);
      reset_per_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_to = 0;
      exp_stray = 0;
      @(negedge clk_per);
      reset_per_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_per);
        check_eq("post_reset_no_rsp", rsp_vld, 0);
      end
      exp_stray = 1;
      check_eq("post_reset_stray", stray_ack_cnt, 1);
      check_eq("post_reset_rd_pulses", rd_pulses - rd0, 1);
      $display("reset in WAIT -> stray_ack_cnt=%0d timeout_cnt=%0d", stray_ack_cnt, timeout_cnt);
    end
    do_cmd(1'b0, 16'h0008, '0, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
